// File: rtl/lcd_text_writer_if.sv
// lcd_text_writer_if: request channel into the LCD text writer.
//   master : producer side  - drives wr_valid/wr_rs/wr_data/wr_len/wr_row/wr_col, samples wr_ready
//   slave  : controller side - samples the request fields, drives wr_ready
// wr_data carries up to N_CHARS characters, first character in the top byte.
interface lcd_text_writer_if #(
   parameter int N_CHARS = 16
);
   logic                           wr_valid;
   logic                           wr_ready;
   logic                           wr_rs;
   logic [8*N_CHARS-1:0]           wr_data;
   logic [$clog2(N_CHARS+1)-1:0]   wr_len;
   logic                           wr_row;
   logic [3:0]                     wr_col;

   modport master (
      output wr_valid, wr_rs, wr_data, wr_len, wr_row, wr_col,
      input  wr_ready
   );

   modport slave (
      input  wr_valid, wr_rs, wr_data, wr_len, wr_row, wr_col,
      output wr_ready
   );
endinterface

// File: rtl/lcd_text_writer.sv
// lcd_text_writer: HD44780 16x2 character-LCD controller.
// Runs the power-up/init sequence itself, then accepts raw command bytes or
// strings of up to N_CHARS characters at a given row/column over the wr channel.
// All bus timing comes from parametrised cycle counts.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   wr (slave)     request channel (valid/ready, rs, data, len, row, col)
//   init_done      high once the init sequence has completed
//   LCD_DATA       LCD data bus (always driven, write-only)
//   LCD_RW         tied 0
//   LCD_RS         register select
//   LCD_EN         enable strobe
//   LCD_ON         tied 1
//   LCD_BLON       backlight, constant BLON
//
// Build option: define LCD_AUTOWRAP_EN to continue a string past column 15
// on the other row; otherwise the overflowing characters are dropped.
//
// state   | meaning
// --------+----------------------------------------------------------
// PWRUP   | waiting T_PWRUP cycles after reset
// INIT    | issuing the five init bytes (init_idx selects the byte)
// IDLE    | wr_ready high, waiting for a request
// START   | request captured, choosing command / address / nothing
// CMD     | bus cycle for a raw command byte
// ADDR    | bus cycle for a DDRAM address byte
// CHAR    | bus cycle for a character byte
//
// phase   | meaning (bus sub-machine, runs inside INIT/CMD/ADDR/CHAR)
// --------+----------------------------------------------------------
// NONE    | no bus cycle in progress
// SETUP   | RS/DATA driven, EN low, 1 cycle
// PULSE   | EN high for T_EN cycles
// HOLD    | EN low, RS/DATA stable for T_CMD or T_CLR cycles
module lcd_text_writer #(
   parameter int N_CHARS = 16,
   parameter int T_PWRUP = 750000,
   parameter int T_EN    = 25,
   parameter int T_CMD   = 2500,
   parameter int T_CLR   = 100000,
   parameter bit BLON    = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   lcd_text_writer_if.slave wr,
   output logic             init_done,
   inout  wire  [7:0]       LCD_DATA,
   output logic             LCD_RW,
   output logic             LCD_RS,
   output logic             LCD_EN,
   output logic             LCD_ON,
   output logic             LCD_BLON
);

   localparam int LW = $clog2(N_CHARS + 1);
   localparam int DW = 8 * N_CHARS;

   localparam logic [31:0] T_PWRUP_M1 = 32'(T_PWRUP - 1);
   localparam logic [31:0] T_EN_M1    = 32'(T_EN - 1);
   localparam logic [31:0] T_CMD_M1   = 32'(T_CMD - 1);
   localparam logic [31:0] T_CLR_M1   = 32'(T_CLR - 1);

   typedef enum logic [2:0] {
      S_PWRUP, S_INIT, S_IDLE, S_START, S_CMD, S_ADDR, S_CHAR
   } state_t;

   typedef enum logic [1:0] {
      P_NONE, P_SETUP, P_PULSE, P_HOLD
   } phase_t;

   state_t          state;
   phase_t          phase;
   logic [31:0]     cnt;
   logic [2:0]      init_idx;
   logic            req_rs;
   logic [DW-1:0]   req_sr;
   logic [LW-1:0]   left;
   logic            row_c;
   logic [3:0]      col_c;
   logic [7:0]      data_q;
   logic            rs_q;
   logic            en_q;
   logic            ready_q;
   logic            done_q;

   logic [LW-1:0]   len_clamped;
   logic            hold_long;

   function automatic logic [7:0] init_byte(input logic [2:0] i);
      case (i)
         3'd0:    init_byte = 8'h38;
         3'd1:    init_byte = 8'h38;
         3'd2:    init_byte = 8'h0C;
         3'd3:    init_byte = 8'h01;
         default: init_byte = 8'h06;
      endcase
   endfunction

   // 0x01..0x03 are clear/home: they reset the cursor and need the long wait
   function automatic logic is_home(input logic [7:0] b);
      is_home = (b[7:2] == 6'd0) && (b[1:0] != 2'd0);
   endfunction

   assign len_clamped = (wr.wr_len > LW'(N_CHARS)) ? LW'(N_CHARS) : wr.wr_len;
   assign hold_long   = !rs_q && is_home(data_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_PWRUP;
         phase    <= P_NONE;
         cnt      <= T_PWRUP_M1;
         init_idx <= 3'd0;
         req_rs   <= 1'b0;
         req_sr   <= '0;
         left     <= '0;
         row_c    <= 1'b0;
         col_c    <= 4'd0;
         data_q   <= 8'h00;
         rs_q     <= 1'b0;
         en_q     <= 1'b0;
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
      end else if (phase == P_SETUP) begin
         en_q  <= 1'b1;
         cnt   <= T_EN_M1;
         phase <= P_PULSE;
      end else if (phase == P_PULSE) begin
         if (cnt == 32'd0) begin
            en_q  <= 1'b0;
            cnt   <= hold_long ? T_CLR_M1 : T_CMD_M1;
            phase <= P_HOLD;
         end else begin
            cnt <= cnt - 32'd1;
         end
      end else if (phase == P_HOLD && cnt != 32'd0) begin
         cnt <= cnt - 32'd1;
      end else begin
         // Either no bus cycle is running, or the last HOLD cycle is ending:
         // decide what the next byte is so it follows the HOLD back-to-back.
         phase <= P_NONE;
         case (state)
            S_PWRUP: begin
               if (cnt == 32'd0) begin
                  state    <= S_INIT;
                  init_idx <= 3'd0;
                  data_q   <= init_byte(3'd0);
                  rs_q     <= 1'b0;
                  phase    <= P_SETUP;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            S_INIT: begin
               if (init_idx == 3'd4) begin
                  state   <= S_IDLE;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
               end else begin
                  init_idx <= init_idx + 3'd1;
                  data_q   <= init_byte(init_idx + 3'd1);
                  rs_q     <= 1'b0;
                  phase    <= P_SETUP;
               end
            end
            S_IDLE: begin
               if (wr.wr_valid && ready_q) begin
                  ready_q <= 1'b0;
                  state   <= S_START;
                  req_rs  <= wr.wr_rs;
                  req_sr  <= wr.wr_data;
                  left    <= len_clamped;
                  if (wr.wr_rs) begin
                     row_c <= wr.wr_row;
                     col_c <= wr.wr_col;
                  end
               end
            end
            S_START: begin
               if (!req_rs) begin
                  state  <= S_CMD;
                  data_q <= req_sr[7:0];
                  rs_q   <= 1'b0;
                  phase  <= P_SETUP;
                  if (is_home(req_sr[7:0])) begin
                     row_c <= 1'b0;
                     col_c <= 4'd0;
                  end
               end else if (left == '0) begin
                  state   <= S_IDLE;
                  ready_q <= 1'b1;
               end else begin
                  state  <= S_ADDR;
                  data_q <= {1'b1, row_c, 2'b00, col_c};
                  rs_q   <= 1'b0;
                  phase  <= P_SETUP;
               end
            end
            S_CMD: begin
               state   <= S_IDLE;
               ready_q <= 1'b1;
            end
            S_ADDR: begin
               state  <= S_CHAR;
               data_q <= req_sr[DW-1 -: 8];
               rs_q   <= 1'b1;
               req_sr <= req_sr << 8;
               left   <= left - LW'(1);
               phase  <= P_SETUP;
            end
            S_CHAR: begin
               col_c <= col_c + 4'd1;
               if (left == '0) begin
                  state   <= S_IDLE;
                  ready_q <= 1'b1;
               end else if (col_c == 4'hF) begin
`ifdef LCD_AUTOWRAP_EN
                  row_c  <= ~row_c;
                  state  <= S_ADDR;
                  data_q <= row_c ? 8'h80 : 8'hC0;
                  rs_q   <= 1'b0;
                  phase  <= P_SETUP;
`else
                  state   <= S_IDLE;
                  ready_q <= 1'b1;
`endif
               end else begin
                  data_q <= req_sr[DW-1 -: 8];
                  rs_q   <= 1'b1;
                  req_sr <= req_sr << 8;
                  left   <= left - LW'(1);
                  phase  <= P_SETUP;
               end
            end
            default: begin
               state <= S_PWRUP;
               cnt   <= T_PWRUP_M1;
            end
         endcase
      end
   end

   assign wr.wr_ready = ready_q;
   assign init_done   = done_q;
   assign LCD_DATA    = data_q;
   assign LCD_RS      = rs_q;
   assign LCD_EN      = en_q;
   assign LCD_RW      = 1'b0;
   assign LCD_ON      = 1'b1;
   assign LCD_BLON    = BLON;

endmodule

// File: tb/tb_lcd_text_writer.sv
module tb_lcd_text_writer;

   localparam int NC     = 4;
   localparam int TPWR   = 20;
   localparam int TEN    = 2;
   localparam int TCMD   = 5;
   localparam int TCLR   = 10;
   localparam int BOUND  = 2000;

   logic       clk;
   logic       rst;
   wire  [7:0] lcd_data;
   logic       lcd_rw, lcd_rs, lcd_en, lcd_on, lcd_blon, init_done;

   lcd_text_writer_if #(.N_CHARS(NC)) wr ();

   lcd_text_writer #(
      .N_CHARS(NC), .T_PWRUP(TPWR), .T_EN(TEN), .T_CMD(TCMD), .T_CLR(TCLR), .BLON(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .wr(wr.slave), .init_done(init_done),
      .LCD_DATA(lcd_data), .LCD_RW(lcd_rw), .LCD_RS(lcd_rs), .LCD_EN(lcd_en),
      .LCD_ON(lcd_on), .LCD_BLON(lcd_blon)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rs;
      logic [7:0] d;
      int         hold;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, want, $time);
      end
   endtask

   task automatic push(input logic rs, input logic [7:0] d);
      exp_t e;
      e.rs   = rs;
      e.d    = d;
      e.hold = (!rs && d >= 8'h01 && d <= 8'h03) ? TCLR : TCMD;
      exp_q.push_back(e);
   endtask

   task automatic push_init();
      push(1'b0, 8'h38);
      push(1'b0, 8'h38);
      push(1'b0, 8'h0C);
      push(1'b0, 8'h01);
      push(1'b0, 8'h06);
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic       en_d, rdy_d;
   logic [8:0] prev_v, rise_v, cur_v;
   int         hi_cnt, lo_cnt, stab, last_hold;
   bit         seen;
   exp_t       got_e;

   always @(negedge clk) begin
      cur_v = {lcd_rs, lcd_data};
      if (rst) begin
         en_d = 1'b0; rdy_d = 1'b0; prev_v = cur_v;
         hi_cnt = 0; lo_cnt = 0; stab = 0; last_hold = 0; seen = 1'b0;
      end else begin
         if (cur_v != prev_v) stab = 0;
         else stab++;
         if (lcd_en && !en_d) begin
            chk("setup_stable", 32'(stab >= 1), 32'd1);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_byte got=%0h expected=none t=%0t", cur_v, $time);
               last_hold = TCMD;
            end else begin
               got_e = exp_q.pop_front();
               chk("bus_byte", 32'(cur_v), 32'({got_e.rs, got_e.d}));
               last_hold = got_e.hold;
            end
            rise_v = cur_v;
            hi_cnt = 1;
         end else if (lcd_en) begin
            hi_cnt++;
         end else if (en_d) begin
            chk("pulse_width", hi_cnt, TEN);
            chk("pulse_data_stable", 32'(cur_v), 32'(rise_v));
            lo_cnt = 1;
            seen   = 1'b1;
         end else begin
            lo_cnt++;
            if (seen && cur_v != prev_v)
               chk("hold_time", 32'(lo_cnt > last_hold), 32'd1);
         end
         if (wr.wr_ready && !rdy_d && seen)
            chk("ready_after_hold", 32'(lo_cnt > last_hold), 32'd1);
         en_d   = lcd_en;
         rdy_d  = wr.wr_ready;
         prev_v = cur_v;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic rs, input logic [31:0] data, input logic [2:0] len,
                       input logic row, input logic [3:0] col);
      int n;
      n = 0;
      while (!wr.wr_ready && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_req", 32'(wr.wr_ready), 32'd1);
      @(negedge clk);
      wr.wr_valid = 1'b1;
      wr.wr_rs    = rs;
      wr.wr_data  = data;
      wr.wr_len   = len;
      wr.wr_row   = row;
      wr.wr_col   = col;
      @(posedge clk);
      #1;
      wr.wr_valid = 1'b0;
      @(negedge clk);
      chk("ready_drop", 32'(wr.wr_ready), 32'd0);
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!wr.wr_ready && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_ready"}, 32'(wr.wr_ready), 32'd1);
      chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_en"}, 32'(lcd_en), 32'd0);
      chk({name, "_rs"}, 32'(lcd_rs), 32'd0);
      chk({name, "_data"}, 32'(lcd_data), 32'd0);
      chk({name, "_ready"}, 32'(wr.wr_ready), 32'd0);
      chk({name, "_init_done"}, 32'(init_done), 32'd0);
   endtask

   task automatic run_init(input string name);
      int n;
      push_init();
      @(negedge clk);
      #1 rst = 1'b0;
      n = 0;
      while (!lcd_en && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_pwrup_wait"}, 32'(n >= TPWR), 32'd1);
      chk({name, "_not_done_yet"}, 32'(init_done), 32'd0);
      chk({name, "_not_ready_yet"}, 32'(wr.wr_ready), 32'd0);
      wait_done(name);
      chk({name, "_init_done"}, 32'(init_done), 32'd1);
   endtask

   initial begin
      int n;
      rst         = 1'b1;
      wr.wr_valid = 1'b0;
      wr.wr_rs    = 1'b0;
      wr.wr_data  = '0;
      wr.wr_len   = '0;
      wr.wr_row   = 1'b0;
      wr.wr_col   = 4'd0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      chk("tie_rw", 32'(lcd_rw), 32'd0);
      chk("tie_on", 32'(lcd_on), 32'd1);
      chk("tie_blon", 32'(lcd_blon), 32'd1);

      run_init("init");

      // "ABCD" at row 1, col 2
      push(1'b0, 8'hC2);
      push(1'b1, 8'h41); push(1'b1, 8'h42); push(1'b1, 8'h43); push(1'b1, 8'h44);
      send(1'b1, 32'h41424344, 3'd4, 1'b1, 4'd2);
      wait_done("abcd");

      // "WXYZ" at row 0, col 14: overflow past col 15
      push(1'b0, 8'h8E);
      push(1'b1, 8'h57); push(1'b1, 8'h58);
`ifdef LCD_AUTOWRAP_EN
      push(1'b0, 8'hC0);
      push(1'b1, 8'h59); push(1'b1, 8'h5A);
`endif
      send(1'b1, 32'h5758595A, 3'd4, 1'b0, 4'd14);
      wait_done("wxyz");

      // clear, then one char at home
      push(1'b0, 8'h01);
      send(1'b0, 32'h00000001, 3'd0, 1'b0, 4'd0);
      wait_done("clear");
      push(1'b0, 8'h80);
      push(1'b1, 8'h51);
      send(1'b1, 32'h51000000, 3'd1, 1'b0, 4'd0);
      wait_done("home_char");

      // normal-length command
      push(1'b0, 8'h0E);
      send(1'b0, 32'h0000000E, 3'd0, 1'b0, 4'd0);
      wait_done("cmd_0e");

      // len = 0: no bus activity, ready back the cycle after the drop
      send(1'b1, 32'h41424344, 3'd0, 1'b0, 4'd3);
      @(negedge clk);
      chk("len0_ready_back", 32'(wr.wr_ready), 32'd1);
      wait_done("len0");

      // len = 7 clamps to 4
      push(1'b0, 8'h80);
      push(1'b1, 8'h41); push(1'b1, 8'h42); push(1'b1, 8'h43); push(1'b1, 8'h44);
      send(1'b1, 32'h41424344, 3'd7, 1'b0, 4'd0);
      wait_done("len7");

      // reset while EN is high on a character
      push(1'b0, 8'hC0);
      push(1'b1, 8'h45); push(1'b1, 8'h46); push(1'b1, 8'h47); push(1'b1, 8'h48);
      send(1'b1, 32'h45464748, 3'd4, 1'b1, 4'd0);
      n = 0;
      while (!(lcd_en && lcd_rs) && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      chk("char_pulse_seen", 32'(lcd_en && lcd_rs), 32'd1);
      #1 rst = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      exp_q.delete();
      repeat (3) @(negedge clk);
      run_init("reinit");

      // row 1, col 15 overflow after re-init
      push(1'b0, 8'hCF);
      push(1'b1, 8'h48);
`ifdef LCD_AUTOWRAP_EN
      push(1'b0, 8'h80);
      push(1'b1, 8'h49);
`endif
      send(1'b1, 32'h48490000, 3'd2, 1'b1, 4'd15);
      wait_done("row1_wrap");

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_text_writer.md
Name: lcd_text_writer

Overview:
- Parametrised HD44780 character-LCD controller for the DE2 16x2 module.
- Successor to the fixed 4-char LCD driver:
  - runs its own power-up/init sequence;
  - accepts strings of up to N_CHARS characters at any row/column, or raw command bytes, over a valid/ready handshake;
  - generates all LCD bus timing from parametrised cycle counts.
- Sits between application logic and the LCD_* board pins.

Parameters:
- N_CHARS, 16, maximum characters per request.
- T_PWRUP, 750000, cycles waited after reset before first command (15 ms at 50 MHz).
- T_EN, 25, cycles LCD_EN is held high per bus cycle.
- T_CMD, 2500, cycles waited after EN falls for normal commands and data.
- T_CLR, 100000, cycles waited after EN falls for clear (0x01) or home (0x02/0x03).
- BLON, 1, constant value driven on LCD_BLON.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  request valid
- wr_ready  out  1  controller can accept a request
- wr_rs  in  1  0 = raw command byte in wr_data[7:0]; 1 = character string
- wr_data  in  8*N_CHARS  characters; first char in the top byte
- wr_len  in  $clog2(N_CHARS+1)  character count, for wr_rs=1 only
- wr_row  in  1  start row
- wr_col  in  4  start column
- init_done  out  1  high once the init sequence has completed
- LCD_DATA  inout  8  LCD bus, always driven (write-only)
- LCD_RW  out  1  tied 0
- LCD_RS  out  1  register select
- LCD_EN  out  1  enable strobe
- LCD_ON  out  1  tied 1
- LCD_BLON  out  1  = BLON

Behaviour:
- Reset (asynchronous, immediate, including mid-bus-cycle):
  - LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, wr_ready=0, init_done=0.
  - FSM enters PWRUP. A pending request is discarded.
- Bus cycle (shared sub-machine), for each byte:
  - SETUP: RS/DATA driven, EN=0, 1 cycle.
  - PULSE: EN=1 for T_EN cycles.
  - HOLD: EN=0, RS/DATA stable for T_CMD cycles (T_CLR for command 0x01, 0x02, 0x03).
- States: PWRUP -> INIT -> IDLE -> {CMD | ADDR -> CHAR} -> IDLE.
- PWRUP: wait T_PWRUP cycles.
- INIT: bytes 0x38, 0x38, 0x0C, 0x01, 0x06 in order, RS=0. Then init_done=1 permanently until reset.
- IDLE: wr_ready=1. Accept on the rising edge where wr_valid&&wr_ready.
  - Capture all wr_* inputs.
  - wr_ready falls the following cycle.
  - wr_ready stays low until the last HOLD of the request completes; it is high again the cycle after.
- CMD (wr_rs=0): one bus cycle, RS=0, wr_data[7:0].
  - For 0x01/0x02/0x03, the internal cursor resets to row 0, col 0.
- String (wr_rs=1):
  - len = min(wr_len, N_CHARS).
  - len=0: no bus activity; wr_ready returns 1 the cycle after acceptance.
  - Otherwise ADDR issues RS=0 byte 0x80 | (row?0x40:0x00) | col.
  - Then CHAR issues len bytes, RS=1, in order from the top byte downward.
  - Column increments after each char.
- Column overflow (char written at col 15 with more remaining): see Optional Feature.
- Internal cursor (row, col) is kept after each request.
- wr_valid while busy is ignored; the request must be held by the producer.

Optional Feature:
- Macro: LCD_AUTOWRAP_EN.
- Defined:
  - After a char at col 15, if chars remain, issue address byte 0xC0 (row 0 -> row 1) or 0x80 (row 1 -> row 0), then continue at col 0.
  - The extra address cycle uses T_CMD.
- Undefined:
  - Remaining chars past col 15 are dropped with no bus cycles.
  - The request ends and wr_ready returns after the last issued HOLD.

Test Plan:
All tests use T_PWRUP=20, T_EN=2, T_CMD=5, T_CLR=10, N_CHARS=4.
- Reset release -> LCD_EN low 20 cycles; then bus bytes 0x38, 0x38, 0x0C, 0x01, 0x06 with RS=0; the 0x01 HOLD lasts 10 cycles; init_done=1 and wr_ready=1 after the last HOLD.
- String "ABCD", len=4, row=1, col=2 -> bytes 0xC2 (RS=0), then 0x41, 0x42, 0x43, 0x44 (RS=1); each EN pulse is 2 cycles with RS/DATA stable 1 cycle before and 5 after; wr_ready=0 throughout.
- String "WXYZ", row=0, col=14 -> bytes 0x8E, 'W', 'X'. With LCD_AUTOWRAP_EN: then 0xC0, 'Y', 'Z'. Without: request ends after 'X'.
- Command 0x01 -> one RS=0 cycle with a 10-cycle HOLD; a following string with len=1, row=0, col=0 issues 0x80, char.
- wr_len=0 or wr_len=7 -> len=0: no EN pulse, wr_ready back in 2 cycles; len=7: clamped to 4 chars.
- Assert rst during the EN-high phase of a char -> LCD_EN=0 the same cycle (asynchronous); wr_ready=0 and init_done=0; the full PWRUP/INIT sequence repeats.
